// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in / serial-out transmitter with a valid/ready
// input handshake. Each accepted WIDTH-bit word becomes a frame of WIDTH
// serial bits. A word accepted on the last bit of a frame follows with no gap.
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             last, accept;

  assign last     = (cnt_q == LAST);
  // Ready only when nothing is in flight or the final bit is on the wire,
  // and never while reset is held.
  assign in_ready = rstn & ((state_q == IDLE) | ((state_q == SHIFT) & last));
  assign accept   = in_valid & in_ready;

  // Next-state: load on accept, otherwise shift and count through the frame.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sreg_d  = in_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (last) begin
          cnt_d = '0;
          if (accept) begin
            sreg_d = in_data;
          end else begin
            state_d = IDLE;
            sreg_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
        end
      end
      default: state_d = IDLE;
    endcase
    // Output flags are precomputed from next state so they come out of flops.
    sout_d  = 1'b0;
    if (state_d == SHIFT) sout_d = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
    start_d = (state_d == SHIFT) && (cnt_d == '0);
    done_d  = (state_d == SHIFT) && (cnt_d == LAST);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == SHIFT);
  assign sout_valid  = (state_q == SHIFT);
  assign sout        = sout_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: MSB-first and LSB-first instances share stimulus.
// Accepted words push expected serial bits into a scoreboard queue; the
// monitor pops and compares each cycle, plus a serial loopback check.
module tb_piso_shift_tx;

  localparam int W = 4;

  typedef struct {
    logic mb;
    logic lb;
    logic st;
    logic dn;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic m_rdy, m_sout, m_vld, m_fs, m_fd, m_busy;
  logic l_rdy, l_sout, l_vld, l_fs, l_fd, l_busy;

  int n_chk = 0;
  int n_err = 0;

  exp_t         exp_q[$];
  logic [W-1:0] word_q[$];
  logic [W-1:0] lb_reg = '0;
  logic [W-1:0] lb_word = '0;
  logic         lb_pend = 1'b0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m_rdy), .sout(m_sout), .sout_valid(m_vld),
    .frame_start(m_fs), .frame_done(m_fd), .busy(m_busy)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(l_rdy), .sout(l_sout), .sout_valid(l_vld),
    .frame_start(l_fs), .frame_done(l_fd), .busy(l_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serial loopback: shift each valid MSB-first bit into a 4-bit register.
  always @(posedge clk) begin
    if (m_vld) lb_reg <= {lb_reg[W-2:0], m_sout};
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic nonempty;
    logic exp_rdy;
    exp_t e;
    nonempty = (exp_q.size() != 0);
    exp_rdy  = rstn && (!nonempty || exp_q[0].dn);
    chk("m_vld", m_vld, nonempty);
    chk("l_vld", l_vld, nonempty);
    chk("m_busy", m_busy, nonempty);
    chk("l_busy", l_busy, nonempty);
    chk("m_rdy", m_rdy, exp_rdy);
    chk("l_rdy", l_rdy, exp_rdy);
    if (nonempty) begin
      e = exp_q.pop_front();
      chk("m_sout", m_sout, e.mb);
      chk("l_sout", l_sout, e.lb);
      chk("m_fstart", m_fs, e.st);
      chk("l_fstart", l_fs, e.st);
      chk("m_fdone", m_fd, e.dn);
      chk("l_fdone", l_fd, e.dn);
    end else begin
      chk("idle_outs", {26'd0, m_sout, m_fs, m_fd, l_sout, l_fs, l_fd}, 32'd0);
    end
    if (lb_pend) begin
      chk("loopback", lb_reg, lb_word);
      lb_pend = 1'b0;
    end
    if (m_fd && word_q.size() != 0) begin
      lb_word = word_q.pop_front();
      lb_pend = 1'b1;
    end
    if (!rstn) begin
      exp_q.delete();
      word_q.delete();
    end else if (in_valid && exp_rdy) begin
      for (int i = 0; i < W; i++) begin
        e.mb = in_data[W-1-i];
        e.lb = in_data[i];
        e.st = (i == 0);
        e.dn = (i == W-1);
        exp_q.push_back(e);
      end
      word_q.push_back(in_data);
    end
  end

  // Offer a word and wait for acceptance; optionally keep in_valid high.
  task automatic send(input logic [W-1:0] w, input bit hold);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!m_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    idle(3);
    rstn = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", m_rdy, 1);
    @(posedge clk); #1;
    // Single frame 1011, both bit orders.
    send(4'b1011, 1'b0);
    idle(7);
    // Back-to-back A then 5.
    send(4'hA, 1'b1);
    send(4'h5, 1'b0);
    idle(6);
    // in_data changes to F while the 6 frame is in flight.
    send(4'h6, 1'b1);
    send(4'hF, 1'b0);
    idle(6);
    // Reset after two bits of C; a word offered during reset is ignored.
    send(4'hC, 1'b0);
    @(posedge clk); #1;
    rstn     = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h9;
    @(negedge clk);
    chk("rdy_in_rst", m_rdy, 0);
    @(posedge clk); #1;
    rstn     = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("vld_after_abort", m_vld, 0);
    chk("busy_after_abort", m_busy, 0);
    chk("rdy_after_abort", m_rdy, 1);
    @(posedge clk); #1;
    send(4'h3, 1'b0);
    idle(6);
    // Random words, mixing back-to-back and gaps.
    for (int i = 0; i < 20; i++) begin
      send(W'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        idle($urandom_range(0, 3));
      end
    end
    in_valid = 1'b0;
    idle(8);
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 shifts out bit WIDTH-1 first, 0 shifts out bit 0 first.
REQ-003 Port clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 Port rstn  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  high when a parallel word is offered on in_data.
REQ-006 Port in_data  input  WIDTH  parallel word to serialize; it is sampled only when a word is accepted.
REQ-007 Port in_ready  output  1  high when the block will accept a word this cycle.
REQ-008 Port sout  output  1  serial data bit.
REQ-009 Port sout_valid  output  1  high when sout carries a frame bit.
REQ-010 Port frame_start  output  1  high with the first bit of each frame.
REQ-011 Port frame_done  output  1  high with the last bit of each frame.
REQ-012 Port busy  output  1  high while a frame is being shifted out.

Function
REQ-013 The block SHALL implement two states: IDLE and SHIFT.
REQ-014 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; the handshake is combinational, and holding in_valid high while in_ready=0 SHALL have no effect.
REQ-015 On acceptance, the block SHALL register in_data into a WIDTH-bit shift register, set the bit counter to 0, and be in SHIFT from the next cycle.
REQ-016 Latency: the first bit of a frame SHALL appear on sout in the cycle immediately after the acceptance edge.
REQ-017 In SHIFT, sout_valid SHALL be 1 for exactly WIDTH consecutive cycles, presenting one bit per cycle in the order set by MSB_FIRST.
REQ-018 In SHIFT, the counter SHALL increment once per cycle, with width ceil(log2(WIDTH)) bits.
REQ-019 frame_start SHALL be high when the counter is 0 in SHIFT, and frame_done SHALL be high when the counter is WIDTH-1 in SHIFT; both SHALL be low otherwise.
REQ-020 in_ready SHALL equal (state==IDLE) OR (state==SHIFT AND counter==WIDTH-1), gated low while rstn=0.
REQ-021 Back-to-back frames: if a word is accepted on the last-bit cycle, the next frame's first bit SHALL follow with no gap, and sout_valid SHALL stay at 1.
REQ-022 If no word is accepted on the last-bit cycle, the block SHALL return to IDLE, with sout_valid=0 the next cycle.
REQ-023 In IDLE, sout and sout_valid SHALL both be 0.
REQ-024 busy SHALL be 1 exactly when state==SHIFT.
REQ-025 Changes on in_data after acceptance SHALL NOT affect the frame in progress.
REQ-026 All outputs except in_ready SHALL be driven from registers.

Reset
REQ-027 While rstn=0 at a rising edge, the block SHALL move to IDLE and clear the shift register and counter.
REQ-028 After reset, sout, sout_valid, frame_start, frame_done and busy SHALL all be 0.
REQ-029 in_ready SHALL be 0 while rstn=0 and SHALL be 1 in the first cycle after rstn returns to 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame: sout_valid=0 from the next cycle, and no remaining bits are emitted.
REQ-031 A word offered while rstn=0 SHALL NOT be accepted.

Verification (WIDTH=4 unless stated)
REQ-032 Single frame, MSB_FIRST=1, in_data=4'b1011 accepted at edge k -> sout=1,0,1,1 in cycles k+1..k+4; frame_start in k+1 only; frame_done in k+4 only; sout_valid=0 in k+5.
REQ-033 LSB first, MSB_FIRST=0, in_data=4'b1011 -> sout=1,1,0,1.
REQ-034 Back-to-back, in_valid held high with 4'hA then 4'h5 -> 8 contiguous bits 1,0,1,0,0,1,0,1; sout_valid high for all 8 cycles; in_ready high only in IDLE and on bit 4.
REQ-035 Backpressure, in_data changed to 4'hF during the 4'h6 frame while in_valid=1 -> output 0,1,1,0, then the new word 4'hF, i.e. 1,1,1,1.
REQ-036 Reset mid-frame, rstn=0 after 2 bits of 4'hC -> sout_valid=0 and busy=0 the next cycle; in_ready=1 after rstn returns to 1; the next word 4'h3 serializes correctly as 0,0,1,1.
REQ-037 Loopback, sout gated by sout_valid into a 4-bit serial-in left-shift register, 20 random words, MSB_FIRST=1 -> the register equals each word the cycle after its frame_done.
